sort_stream_ctrl: RTL and testbench
===================================

# sort_stream_ctrl

Streaming sequencer for the N-lane systolic odd-even transposition sorter. It accepts 32-bit words over a valid/ready input stream and pads short batches. It pulses the sorter's load, waits the N transposition phases, captures the sorted vector and streams it back out over a valid/ready output stream. It sits between a producer/consumer fabric and one sorter instance, on the same clock.

## Interface
- N, 8, lane count of the attached sorter; legal range 2..64
- clk  in  1  clock, shared with the sorter
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  controller can accept a word
- in_data  in  32  input word, unsigned
- in_last  in  1  final word of the batch; qualified by in_valid
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts the word
- out_data  out  32  sorted output word
- out_last  out  1  final word of the batch
- busy  out  1  high whenever state is not FILL
- sorter_load  out  1  one-cycle load strobe to the sorter
- sorter_in_flat  out  N*32  lane i at bits [i*32 +: 32]
- sorter_out_flat  in  N*32  sorter lane state, same packing; lane 0 is the smallest after N phases

## Operation
- States: FILL, LOAD, SORT, DRAIN. Reset enters FILL.
- FILL:
  - in_ready=1.
  - On each handshake, write in_data to ibuf[wr_cnt] and increment wr_cnt.
  - If wr_cnt==N-1 or in_last=1: store cnt=wr_cnt+1, fill lanes cnt..N-1 with 32'hFFFF_FFFF, clear wr_cnt, then go to LOAD.
- LOAD:
  - One cycle; sorter_load=1, in_ready=0.
  - sorter_in_flat is driven from ibuf in every state.
- SORT:
  - sort_cnt counts 0..N with sorter_load=0.
  - When sort_cnt==N, capture sorter_out_flat into obuf, clear rd_cnt, then go to DRAIN.
- DRAIN:
  - out_valid=1.
  - out_data=obuf[idx], where idx=rd_cnt.
  - out_last=(rd_cnt==cnt-1).
  - Each handshake increments rd_cnt. The handshake with out_last returns the block to FILL.
- Pad words are never emitted. Only cnt words leave the block.
- A real 32'hFFFF_FFFF sorts equal to the pads, so the output is still correct.
- No overlap: in_ready=0 in LOAD, SORT and DRAIN.
- busy=1 in LOAD, SORT and DRAIN.

## Timing
- Reset values: in_ready=1, out_valid=0, out_last=0, out_data=0, sorter_load=0, busy=0, all counters 0.
- ibuf/obuf contents after reset are don't-care.
- Latency:
  - Final input accepted at edge E0.
  - LOAD occupies the cycle after E0; the sorter loads at E1.
  - SORT phases occur at E2..E(N+1); capture happens at E(N+2).
  - out_valid rises after E(N+2), i.e. N+2 cycles after the final input handshake.
- Stall rule: while out_valid=1 and out_ready=0, out_data and out_last hold stable.
- out_valid never drops without a handshake.
- After the out_last handshake, in_ready=1 in the next cycle. Throughput is one word/cycle in FILL and DRAIN.
- in_valid in non-FILL states is ignored and nothing is consumed.
- in_last on the N-th word is treated the same as a full batch.
- rst_n low at any time, including mid-SORT or mid-DRAIN:
  - The block returns to FILL immediately and asynchronously.
  - out_valid drops and any partial batch is discarded.
  - The sorter is not reset by this block.

## Configuration
- SORT_STREAM_DESC_EN:
  - Defined: DRAIN emits in descending order, idx=cnt-1-rd_cnt (lanes cnt-1 down to 0). Pads are still excluded.
  - Undefined: ascending order, idx=rd_cnt.
  - Latency and handshake rules are the same in both builds.

## Test plan
- N=8, full batch 5,3,9,1,7,2,8,4, out_ready=1:
  - Output is 1,2,3,4,5,7,8,9.
  - out_last on 9.
  - First out_valid exactly 10 cycles after the 8th input handshake.
- Short batch 30,10,20 with in_last on 20:
  - Output is 10,20,30 only; out_last on 30.
  - Next cycle in FILL with in_ready=1.
- Batch containing FFFFFFFF,0,FFFFFFFF plus in_last:
  - Output is 0,FFFFFFFF,FFFFFFFF; count is 3 and no pad leaks.
- Random out_ready toggling (~50%) on a full batch:
  - out_data/out_last are stable across stalls.
  - No word is dropped or duplicated.
  - in_ready stays 0 until the final handshake.
- rst_n pulsed low during SORT, then a new batch 2,1 with in_last:
  - All outputs are at reset values during reset.
  - The new batch yields 1,2.
- Build with SORT_STREAM_DESC_EN and input 4,6,5 with in_last:
  - Output is 6,5,4; out_last on 4.

Source files
------------

// File: rtl/sort_stream_ctrl.sv
// rtl/sort_stream_ctrl.sv - stream sequencer for an N-lane odd-even transposition sorter
// Define SORT_STREAM_DESC_EN to drain each batch in descending order.
module sort_stream_ctrl #(
    parameter int N = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic            out_last,
    output logic            busy,
    output logic            sorter_load,
    output logic [N*32-1:0] sorter_in_flat,
    input  logic [N*32-1:0] sorter_out_flat
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] N_M1 = CW'(N - 1);
    localparam logic [CW-1:0] N_C  = CW'(N);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {FILL, LOAD, SORT, DRAIN} state_t;

    state_t          state;
    logic [CW-1:0]   wr_cnt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   sort_cnt;
    logic [CW-1:0]   rd_cnt;
    logic [N*32-1:0] ibuf;
    logic [N*32-1:0] obuf;
    logic [CW-1:0]   first_idx;
    logic [CW-1:0]   next_idx;
    logic            in_fire;
    logic            batch_end;
    logic            capture;

    assign in_fire   = (state == FILL) && in_valid;
    assign batch_end = in_fire && ((wr_cnt == N_M1) || in_last);
    assign capture   = (state == SORT) && (sort_cnt == N_C);
    assign sorter_in_flat = ibuf;

`ifdef SORT_STREAM_DESC_EN
    assign first_idx = cnt - ONE;
    assign next_idx  = cnt - CW'(2) - rd_cnt;
`else
    assign first_idx = '0;
    assign next_idx  = rd_cnt + ONE;
`endif

    // Buffers carry no reset; their contents only matter once a batch is written.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int i = 0; i < N; i++) begin
                if (CW'(i) == wr_cnt)
                    ibuf[i*32 +: 32] <= in_data;
                else if (batch_end && (CW'(i) > wr_cnt))
                    ibuf[i*32 +: 32] <= 32'hFFFF_FFFF;
            end
        end
        if (capture)
            obuf <= sorter_out_flat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
            sorter_load <= 1'b0;
            busy        <= 1'b0;
            wr_cnt      <= '0;
            cnt         <= '0;
            sort_cnt    <= '0;
            rd_cnt      <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (batch_end) begin
                        cnt         <= wr_cnt + ONE;
                        wr_cnt      <= '0;
                        state       <= LOAD;
                        in_ready    <= 1'b0;
                        busy        <= 1'b1;
                        sorter_load <= 1'b1;
                    end else if (in_fire) begin
                        wr_cnt <= wr_cnt + ONE;
                    end
                end
                LOAD: begin
                    sorter_load <= 1'b0;
                    sort_cnt    <= '0;
                    state       <= SORT;
                end
                SORT: begin
                    // The first word comes straight from the sorter so out_data is valid with out_valid.
                    if (capture) begin
                        state     <= DRAIN;
                        rd_cnt    <= '0;
                        out_valid <= 1'b1;
                        out_data  <= sorter_out_flat[int'(first_idx)*32 +: 32];
                        out_last  <= (cnt == ONE);
                    end else begin
                        sort_cnt <= sort_cnt + ONE;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= FILL;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            rd_cnt   <= rd_cnt + ONE;
                            out_data <= obuf[int'(next_idx)*32 +: 32];
                            out_last <= ((rd_cnt + ONE) == (cnt - ONE));
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_sort_stream_ctrl.sv
// tb/tb_sort_stream_ctrl.sv - scoreboard bench for sort_stream_ctrl with a behavioural sorter
module tb_sort_stream_ctrl;
    localparam int N = 8;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_data;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_data;
    logic            out_last;
    logic            busy;
    logic            sorter_load;
    logic [N*32-1:0] sorter_in_flat;
    logic [N*32-1:0] sorter_out_flat;

    int errors = 0;
    int checks = 0;
    logic [32:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sort_stream_ctrl #(.N(N)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_last         (in_last),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_last        (out_last),
        .busy            (busy),
        .sorter_load     (sorter_load),
        .sorter_in_flat  (sorter_in_flat),
        .sorter_out_flat (sorter_out_flat)
    );

    // Odd-even transposition sorter: one compare-exchange phase per cycle after load.
    logic [31:0] lanes [N];
    logic        phase;
    always @(posedge clk) begin
        if (sorter_load) begin
            for (int i = 0; i < N; i++) lanes[i] <= sorter_in_flat[i*32 +: 32];
            phase <= 1'b0;
        end else begin
            for (int i = 0; i + 1 < N; i++) begin
                if (((i % 2) == int'(phase)) && (lanes[i] > lanes[i+1])) begin
                    lanes[i]   <= lanes[i+1];
                    lanes[i+1] <= lanes[i];
                end
            end
            phase <= ~phase;
        end
    end
    for (genvar g = 0; g < N; g++) begin : g_out
        assign sorter_out_flat[g*32 +: 32] = lanes[g];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_expected(input logic [31:0] w[$]);
        logic [31:0] s[$];
        logic [31:0] t;
        s = w;
        for (int i = 0; i < s.size(); i++)
            for (int j = 0; j + 1 < s.size() - i; j++)
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
`ifdef SORT_STREAM_DESC_EN
        for (int i = s.size() - 1; i >= 0; i--) exp_q.push_back({(i == 0), s[i]});
`else
        for (int i = 0; i < s.size(); i++) exp_q.push_back({(i == s.size() - 1), s[i]});
`endif
    endtask

    task automatic send_batch(input logic [31:0] w[$], input bit tag_last);
        int n;
        for (int i = 0; i < w.size(); i++) begin
            in_valid = 1'b1;
            in_data  = w[i];
            in_last  = tag_last && (i == w.size() - 1);
            n = 0;
            while (!in_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) check("in_ready_timeout", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        push_expected(w);
    endtask

    task automatic drain(input bit random_ready, input bit hold_junk);
        int   cyc = 0;
        bit   seen = 0;
        bit   done = 0;
        bit   prev_stall = 0;
        logic [31:0] prev_data = '0;
        logic        prev_last = 1'b0;
        logic [32:0] e;
        if (hold_junk) begin
            in_valid = 1'b1;
            in_data  = 32'hDEAD_0001;
        end
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (out_valid && !seen) begin
                seen = 1;
                check("latency", 32'(cyc - 1), 32'(N + 2));
            end
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", out_data, prev_data);
                check("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid) check("in_ready_drain", 32'(in_ready), 32'd0);
            out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", out_data, 32'hxxxx_xxxx);
                    done = 1;
                end else begin
                    e = exp_q.pop_front();
                    check("data", out_data, e[31:0]);
                    check("last", 32'(out_last), 32'(e[32]));
                    if (out_last) begin
                        done = 1;
                        in_valid = 1'b0;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
        in_valid = 1'b0;
        if (!done) check("drain_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("in_ready_after", 32'(in_ready), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_sorter_load", 32'(sorter_load), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] q[$];
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        q = {32'd5, 32'd3, 32'd9, 32'd1, 32'd7, 32'd2, 32'd8, 32'd4};
        send_batch(q, 1'b0);
        drain(1'b0, 1'b0);

        q = {32'd30, 32'd10, 32'd20};
        send_batch(q, 1'b1);
        drain(1'b0, 1'b1);

        q = {32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
        send_batch(q, 1'b1);
        drain(1'b0, 1'b0);

        q = {};
        for (int i = 0; i < N; i++) q.push_back($urandom);
        send_batch(q, 1'b1);
        drain(1'b1, 1'b0);

        q = {};
        for (int i = 0; i < N; i++) q.push_back($urandom_range(0, 15));
        send_batch(q, 1'b0);
        drain(1'b1, 1'b1);

        q = {32'd50, 32'd40, 32'd60, 32'd45, 32'd55};
        send_batch(q, 1'b1);
        repeat (4) @(negedge clk);
        check("busy_in_sort", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        q = {32'd2, 32'd1};
        send_batch(q, 1'b1);
        drain(1'b0, 1'b0);

        q = {32'd4, 32'd6, 32'd5};
        send_batch(q, 1'b1);
        drain(1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
